soml_tx_encoder: RTL

- Transmit-side counterpart of soml_decoder_top: maps one 12-bit information word to a 4x2 complex space-time codeword S (4 antennas x 2 time slots).
- Streams the 8 codeword entries as Q-format complex samples on a valid/ready interface.
- Output format matches the decoder's Y/H sample format (N-bit signed, Q fractional bits), so the encoder output can feed a channel model and then the decoder in loopback benches.

---
 rtl/soml_tx_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/soml_tx_encoder.sv
// Space-time codeword encoder: maps a 12-bit info word to a 4x2 complex codeword
// and streams its 8 entries row-major as signed Q-format samples over valid/ready.
module soml_tx_encoder #(
  parameter int Q    = 22,
  parameter int N    = 32,
  parameter int LVL1 = 1326355,
  parameter int LVL3 = 3979065
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [11:0]         bits_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_r,
  output logic signed [N-1:0] out_i,
  output logic [1:0]          out_ant,
  output logic                out_slot,
  output logic                out_last
);

  localparam logic signed [N-1:0] P1 = N'(LVL1);
  localparam logic signed [N-1:0] P3 = N'(LVL3);

  typedef enum logic [1:0] {IDLE, MAP, STREAM} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  beat_reg, beat_next;
  logic        in_ready_reg;
  logic [11:0] word_reg;
  logic        capture;

  logic signed [N-1:0] ent_r [8];
  logic signed [N-1:0] ent_i [8];

  // Gray-coded 16-QAM level for one 2-bit field
  function automatic logic signed [N-1:0] qam(input logic [1:0] f);
    case (f)
      2'b00:   qam = -P3;
      2'b01:   qam = -P1;
      2'b11:   qam = P1;
      default: qam = P3;
    endcase
  endfunction

  logic signed [N-1:0] x1_r, x1_i, x2_r, x2_i;
  logic [1:0] a1, a2, rot;

  always_comb begin
    x1_r = qam(word_reg[7:6]);
    x1_i = qam(word_reg[5:4]);
    x2_r = qam(word_reg[3:2]);
    x2_i = qam(word_reg[1:0]);
    rot  = word_reg[11:10];
    a1   = 2'd0;
    a2   = 2'd1;
    case (word_reg[9:8])
      2'b00:   begin a1 = 2'd0; a2 = 2'd1; end
      2'b01:   begin a1 = 2'd2; a2 = 2'd3; end
      2'b10:   begin a1 = 2'd0; a2 = 2'd2; end
      default: begin a1 = 2'd1; a2 = 2'd3; end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ent
      localparam logic [1:0] ANT  = 2'(gi / 2);
      localparam logic       SLOT = 1'(gi % 2);
      logic signed [N-1:0] base_r, base_i, rot_r, rot_i;
      logic signed [N-1:0] val_r_reg, val_i_reg;

      always_comb begin
        base_r = '0;
        base_i = '0;
        if (ANT == a1) begin
          base_r = SLOT ? -x2_r : x1_r;
          base_i = SLOT ?  x2_i : x1_i;
        end else if (ANT == a2) begin
          base_r = SLOT ?  x1_r : x2_r;
          base_i = SLOT ? -x1_i : x2_i;
        end
        // multiply by j^rot using only swaps and negations
        case (rot)
          2'd1:    begin rot_r = -base_i; rot_i =  base_r; end
          2'd2:    begin rot_r = -base_r; rot_i = -base_i; end
          2'd3:    begin rot_r =  base_i; rot_i = -base_r; end
          default: begin rot_r =  base_r; rot_i =  base_i; end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          val_r_reg <= '0;
          val_i_reg <= '0;
        end else if (state_reg == MAP) begin
          val_r_reg <= rot_r;
          val_i_reg <= rot_i;
        end
      end

      assign ent_r[gi] = val_r_reg;
      assign ent_i[gi] = val_i_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          state_next = MAP;
          capture    = 1'b1;
        end
      end
      MAP: begin
        state_next = STREAM;
        beat_next  = 3'd0;
      end
      STREAM: begin
        if (out_ready) begin
          if (beat_reg == 3'd7) begin
            state_next = IDLE;
            beat_next  = 3'd0;
          end else begin
            beat_next = beat_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_reg     <= 3'd0;
      in_ready_reg <= 1'b0;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      in_ready_reg <= (state_next == IDLE);
      if (capture) word_reg <= bits_in;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == STREAM);
  assign out_r     = out_valid ? ent_r[beat_reg] : '0;
  assign out_i     = out_valid ? ent_i[beat_reg] : '0;
  assign out_ant   = out_valid ? beat_reg[2:1] : 2'd0;
  assign out_slot  = out_valid ? beat_reg[0] : 1'b0;
  assign out_last  = out_valid && (beat_reg == 3'd7);

endmodule
